// File: rtl/eb_pkg.sv
`default_nettype none
// ============================================================================
// Module : eb_pkg
// Shared types and the round-robin pick helper for elastic_buffer front ends.
// Rev    : 1.0
// ============================================================================
package eb_pkg;

    localparam int DATA_LENGHT_DEF = 16;
    localparam int RR_MAX_REQ      = 16;
    localparam int RR_IDX_W        = 4;

    typedef logic [DATA_LENGHT_DEF-1:0] data_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Returns {found, index}: first set bit of valid scanning start, start+1, ... mod n.
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   start,
        input int                    n
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        int                  k;
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            k = (int'(start) + i) % n;
            if ((i < n) && !found && valid[k[RR_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = k[RR_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/eb_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick_comb
// Rotating priority encoder: first valid index at or after i_start, wrapping.
// Rev    : 1.0
// ============================================================================
module rr_pick_comb
    import eb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IW-1:0]      i_start,
    output logic               o_found,
    output logic [IW-1:0]      o_idx
);

    logic [IW-1:0] w_k;

    // Scan from the far end so the candidate closest to i_start overwrites last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_k     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = IW'((int'(i_start) + i) % NUM_REQ);
            if (i_valid[w_k]) begin
                o_found = 1'b1;
                o_idx   = w_k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : eb_rr_arbiter
// Burst-limited round-robin arbiter feeding one registered elastic_buffer port.
// Rev    : 1.0
// ============================================================================
module eb_rr_arbiter
    import eb_pkg::*;
#(
    parameter int DATA_LENGHT = 16,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             i_valid,
    input  logic [NUM_REQ*DATA_LENGHT-1:0] i_data,
    output logic [NUM_REQ-1:0]             i_ready,
    output logic                           o_valid,
    output logic [DATA_LENGHT-1:0]         o_data,
    output logic [$clog2(NUM_REQ)-1:0]     o_src,
    input  logic                           o_ready
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [IW-1:0]          r_owner;
    logic [CW-1:0]          r_cnt;
    arb_state_e             r_state;
    logic                   r_valid;
    logic [DATA_LENGHT-1:0] r_data;
    logic [IW-1:0]          r_src;

    logic                   w_load;
    logic                   w_keep;
    logic [IW-1:0]          w_start;
    logic                   w_pick_found;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_found;
    logic [IW-1:0]          w_win;
    logic [DATA_LENGHT-1:0] w_win_data;

    assign w_load  = !r_valid || o_ready;
    assign w_start = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);

    // Burst continuation only while the count is below the limit; afterwards the
    // owner sits last in the scan, so a lone requester still gets re-granted.
    assign w_keep  = (r_state == BURST) && i_valid[r_owner] && (r_cnt < CW'(MAX_BURST));

    rr_pick_comb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_valid (i_valid),
        .i_start (w_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_found    = w_keep || w_pick_found;
    assign w_win      = w_keep ? r_owner : w_pick_idx;
    assign w_win_data = i_data[int'(w_win) * DATA_LENGHT +: DATA_LENGHT];

    always_comb begin
        i_ready = '0;
        if (rst_n && w_load && w_found) begin
            i_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= IW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_win_data;
                r_src   <= w_win;
                if (w_keep) begin
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_owner <= w_win;
                    r_cnt   <= CW'(1);
                    r_state <= BURST;
                end
            end else begin
                r_valid <= 1'b0;
                r_cnt   <= '0;
                r_state <= IDLE;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;

endmodule
`default_nettype wire
